// File: rtl/hdu_seq.sv
// Sequential hazard detection unit.
// Detects load-use and branch-operand hazards, then holds PC and IF/ID for a
// fixed number of bubble cycles using a small down-counter, so the stall
// length does not depend on upstream inputs staying stable. An external
// front-end hold freezes the unit. The unit also reports a hazard code and
// keeps a saturating count of inserted bubbles.
module hdu_seq #(
    parameter int              REG_W           = 5,
    parameter int              OP_W            = 6,
    parameter int              LOAD_USE_STALLS = 1,
    parameter bit              BRANCH_IN_ID    = 1'b1,
    parameter logic [OP_W-1:0] BEQ_OP          = OP_W'(6'b000100),
    parameter logic [OP_W-1:0] BNE_OP          = OP_W'(6'b000101),
    parameter int              PERF_W          = 32
) (
    input  logic                      clock_in,
    input  logic                      reset_in,
    input  logic                      hold_in,
    input  logic                      id_ex_memRead,
    input  logic                      id_ex_regWrite,
    input  logic [REG_W-1:0]          id_ex_rt,
    input  logic [REG_W-1:0]          id_ex_dst,
    input  logic                      ex_mem_memRead,
    input  logic [REG_W-1:0]          ex_mem_dst,
    input  logic [OP_W+2*REG_W-1:0]   instruction2msb_in,
    output logic                      pc_wr_out,
    output logic                      if_id_wr_out,
    output logic                      flush_control_out,
    output logic [1:0]                hazard_out,
    output logic [PERF_W-1:0]         stall_count_out
);

    localparam int INSTR_W = OP_W + 2*REG_W;
    // Counter must hold the longest demand, LOAD_USE_STALLS+1.
    localparam int CNT_W   = $clog2(LOAD_USE_STALLS + 2);

    localparam logic [1:0] HZ_NONE   = 2'b00;
    localparam logic [1:0] HZ_LOAD   = 2'b01;
    localparam logic [1:0] HZ_BR_ALU = 2'b10;
    localparam logic [1:0] HZ_BR_LD  = 2'b11;

    typedef enum logic {S_IDLE, S_STALL} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         code_q;
    logic [PERF_W-1:0]  perf_q;

    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rs, rt;
    logic               rs_used, rt_used, is_branch;
    logic [CNT_W-1:0]   dem_n;
    logic [1:0]         dem_code;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    function automatic logic hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Split the instruction head and work out which source fields are read.
    always_comb begin
        opcode    = instruction2msb_in[INSTR_W-1 -: OP_W];
        rs        = instruction2msb_in[2*REG_W-1:REG_W];
        rt        = instruction2msb_in[REG_W-1:0];
        is_branch = (opcode == BEQ_OP) || (opcode == BNE_OP);
        rt_used   = (opcode == '0) || is_branch || (opcode == OP_W'(6'b101011));
        rs_used   = !((opcode == OP_W'(2)) || (opcode == OP_W'(3)) ||
                      (opcode == OP_W'(6'b001111)));
    end

    // Collect stall demands; candidates go from lowest to highest tie priority
    // (10, 01, 11) so '>=' lets the later, higher-priority code win ties.
    always_comb begin
        dem_n    = '0;
        dem_code = HZ_NONE;
        if (BRANCH_IN_ID && is_branch && !(id_ex_memRead &&
                (hit(rs, id_ex_rt) || hit(rt, id_ex_rt))) &&
                id_ex_regWrite && (hit(rs, id_ex_dst) || hit(rt, id_ex_dst))) begin
            dem_n    = CNT_W'(1);
            dem_code = HZ_BR_ALU;
        end
        if (id_ex_memRead && ((rs_used && hit(rs, id_ex_rt)) ||
                              (rt_used && hit(rt, id_ex_rt))) &&
                CNT_W'(LOAD_USE_STALLS) >= dem_n) begin
            dem_n    = CNT_W'(LOAD_USE_STALLS);
            dem_code = HZ_LOAD;
        end
        if (BRANCH_IN_ID && is_branch && ex_mem_memRead &&
                (hit(rs, ex_mem_dst) || hit(rt, ex_mem_dst)) &&
                CNT_W'(LOAD_USE_STALLS) >= dem_n) begin
            dem_n    = CNT_W'(LOAD_USE_STALLS);
            dem_code = HZ_BR_LD;
        end
        if (BRANCH_IN_ID && is_branch && id_ex_memRead &&
                (hit(rs, id_ex_rt) || hit(rt, id_ex_rt))) begin
            dem_n    = CNT_W'(LOAD_USE_STALLS + 1);
            dem_code = HZ_BR_LD;
        end
    end

    // Pipeline control: reset forces a bubble, hold freezes the front end
    // without a bubble, otherwise stall while in STALL or on a fresh demand.
    always_comb begin
        pc_wr_out         = 1'b1;
        if_id_wr_out      = 1'b1;
        flush_control_out = 1'b0;
        hazard_out        = HZ_NONE;
        if (reset_in) begin
            pc_wr_out         = 1'b0;
            if_id_wr_out      = 1'b0;
            flush_control_out = 1'b1;
        end else if (hold_in) begin
            pc_wr_out    = 1'b0;
            if_id_wr_out = 1'b0;
            hazard_out   = (state_q == S_STALL) ? code_q : HZ_NONE;
        end else if (state_q == S_STALL) begin
            pc_wr_out         = 1'b0;
            if_id_wr_out      = 1'b0;
            flush_control_out = 1'b1;
            hazard_out        = code_q;
        end else if (dem_n != '0) begin
            pc_wr_out         = 1'b0;
            if_id_wr_out      = 1'b0;
            flush_control_out = 1'b1;
            hazard_out        = dem_code;
        end
    end

    // Stall FSM: the first bubble is issued from IDLE, the remaining N-1 are
    // counted down in STALL. Hold freezes state and counter.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= HZ_NONE;
        end else if (!hold_in) begin
            case (state_q)
                S_IDLE: begin
                    if (dem_n > CNT_W'(1)) begin
                        cnt_q   <= dem_n - CNT_W'(1);
                        code_q  <= dem_code;
                        state_q <= S_STALL;
                    end
                end
                S_STALL: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Saturating bubble counter; flush is never high during hold.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in)
            perf_q <= '0;
        else if (flush_control_out && (perf_q != {PERF_W{1'b1}}))
            perf_q <= perf_q + PERF_W'(1);
    end

    assign stall_count_out = perf_q;

endmodule

// File: tb/tb_hdu_seq.sv
// Bench for hdu_seq: three instances share stimulus (L=1 branch-in-ID,
// L=3 branch-in-ID, L=2 branch-in-EX with a 4-bit counter to reach
// saturation). A bubble-budget model checks every instance on every cycle.
module tb_hdu_seq;

    logic        clk, rst, hold;
    logic        mr, rw, emr;
    logic [4:0]  irt, idst, edst;
    logic [15:0] ins;

    logic [2:0]      pc_w, ifid_w, fl_w;
    logic [2:0][1:0] hz_w;
    logic [31:0]     sc0, sc1;
    logic [3:0]      sc2;

    int checks = 0;
    int errors = 0;

    hdu_seq #(.LOAD_USE_STALLS(1), .BRANCH_IN_ID(1'b1), .PERF_W(32)) u1 (
        .clock_in(clk), .reset_in(rst), .hold_in(hold),
        .id_ex_memRead(mr), .id_ex_regWrite(rw), .id_ex_rt(irt), .id_ex_dst(idst),
        .ex_mem_memRead(emr), .ex_mem_dst(edst), .instruction2msb_in(ins),
        .pc_wr_out(pc_w[0]), .if_id_wr_out(ifid_w[0]), .flush_control_out(fl_w[0]),
        .hazard_out(hz_w[0]), .stall_count_out(sc0));

    hdu_seq #(.LOAD_USE_STALLS(3), .BRANCH_IN_ID(1'b1), .PERF_W(32)) u3 (
        .clock_in(clk), .reset_in(rst), .hold_in(hold),
        .id_ex_memRead(mr), .id_ex_regWrite(rw), .id_ex_rt(irt), .id_ex_dst(idst),
        .ex_mem_memRead(emr), .ex_mem_dst(edst), .instruction2msb_in(ins),
        .pc_wr_out(pc_w[1]), .if_id_wr_out(ifid_w[1]), .flush_control_out(fl_w[1]),
        .hazard_out(hz_w[1]), .stall_count_out(sc1));

    hdu_seq #(.LOAD_USE_STALLS(2), .BRANCH_IN_ID(1'b0), .PERF_W(4)) u0 (
        .clock_in(clk), .reset_in(rst), .hold_in(hold),
        .id_ex_memRead(mr), .id_ex_regWrite(rw), .id_ex_rt(irt), .id_ex_dst(idst),
        .ex_mem_memRead(emr), .ex_mem_dst(edst), .instruction2msb_in(ins),
        .pc_wr_out(pc_w[2]), .if_id_wr_out(ifid_w[2]), .flush_control_out(fl_w[2]),
        .hazard_out(hz_w[2]), .stall_count_out(sc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model parameters and state per instance.
    int      p_l[3]   = '{1, 3, 2};
    bit      p_br[3]  = '{1'b1, 1'b1, 1'b0};
    longint  p_max[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    int      m_rem[3];
    logic [1:0] m_code[3];
    longint  m_cnt[3];

    typedef struct {
        logic        mr, rw, emr;
        logic [4:0]  irt, idst, edst;
        logic [15:0] ins;
        logic [4:0]  exp;   // u1 first-cycle {pc, ifid, flush, hazard}
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(logic m, logic w, logic [4:0] r, logic [4:0] d,
                                logic e, logic [4:0] ed, logic [5:0] op,
                                logic [4:0] s, logic [4:0] t, logic [4:0] x);
        vec_t v;
        v.mr = m; v.rw = w; v.irt = r; v.idst = d; v.emr = e; v.edst = ed;
        v.ins = {op, s, t}; v.exp = x;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit hit(logic [4:0] a, logic [4:0] b);
        return a != 5'd0 && a == b;
    endfunction

    function automatic int rank(logic [1:0] c);
        return (c == 2'b11) ? 3 : (c == 2'b01) ? 2 : (c == 2'b10) ? 1 : 0;
    endfunction

    // Bubble demand straight from the hazard rules: largest count wins,
    // ties broken by code rank.
    task automatic demand(input int l, input bit br, output int n, output logic [1:0] code);
        logic [5:0] op;
        logic [4:0] s, t;
        bit su, tu, isb;
        int dn[$];
        logic [1:0] dc[$];
        op = ins[15:10]; s = ins[9:5]; t = ins[4:0];
        isb = (op == 6'd4) || (op == 6'd5);
        tu = (op == 6'd0) || isb || (op == 6'd43);
        su = !((op == 6'd2) || (op == 6'd3) || (op == 6'd15));
        if (mr && ((su && hit(s, irt)) || (tu && hit(t, irt)))) begin dn.push_back(l); dc.push_back(2'b01); end
        if (br && isb) begin
            if (mr && (hit(s, irt) || hit(t, irt))) begin dn.push_back(l + 1); dc.push_back(2'b11); end
            else if (rw && (hit(s, idst) || hit(t, idst))) begin dn.push_back(1); dc.push_back(2'b10); end
            if (emr && (hit(s, edst) || hit(t, edst))) begin dn.push_back(l); dc.push_back(2'b11); end
        end
        n = 0; code = 2'b00;
        foreach (dn[i])
            if (dn[i] > n || (dn[i] == n && rank(dc[i]) > rank(code))) begin
                n = dn[i]; code = dc[i];
            end
    endtask

    task automatic model_check(input int k);
        int n;
        logic [1:0] c;
        longint cnt_got;
        logic [4:0] got;
        cnt_got = (k == 0) ? longint'(sc0) : (k == 1) ? longint'(sc1) : longint'(sc2);
        got = {pc_w[k], ifid_w[k], fl_w[k], hz_w[k]};
        if (rst) begin
            chk($sformatf("m%0d_reset_out", k), got, 5'b00100);
            chk($sformatf("m%0d_reset_cnt", k), cnt_got, 0);
            m_rem[k] = 0; m_cnt[k] = 0;
            return;
        end
        chk($sformatf("m%0d_count", k), cnt_got, m_cnt[k]);
        if (hold) begin
            chk($sformatf("m%0d_hold_out", k), got[4:2], 3'b000);
        end else if (m_rem[k] > 0) begin
            chk($sformatf("m%0d_stall_out", k), got, {3'b001, m_code[k]});
            m_rem[k]--;
            if (m_cnt[k] < p_max[k]) m_cnt[k]++;
        end else begin
            demand(p_l[k], p_br[k], n, c);
            if (n > 0) begin
                chk($sformatf("m%0d_new_stall", k), got, {3'b001, c});
                m_rem[k] = n - 1; m_code[k] = c;
                if (m_cnt[k] < p_max[k]) m_cnt[k]++;
            end else begin
                chk($sformatf("m%0d_idle", k), got, 5'b11000);
            end
        end
    endtask

    // One cycle: sample at the falling edge, then move inputs just after rise.
    task automatic step(input bit has_exp, input logic [4:0] exp, input string name);
        @(negedge clk);
        for (int k = 0; k < 3; k++) model_check(k);
        if (has_exp) chk(name, {pc_w[0], ifid_w[0], fl_w[0], hz_w[0]}, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mr = 0; rw = 0; emr = 0; irt = 0; idst = 0; edst = 0; ins = 0; hold = 0;
    endtask

    task automatic set_in(input vec_t v);
        mr = v.mr; rw = v.rw; emr = v.emr; irt = v.irt; idst = v.idst;
        edst = v.edst; ins = v.ins;
    endtask

    initial begin
        longint c0;
        tbl[0]  = mk(1, 0, 8,  0, 0, 0,  6'd0,  8, 16, 5'b00101); // load-use on rs
        tbl[1]  = mk(1, 0, 0,  0, 0, 0,  6'd0,  0, 0,  5'b11000); // register 0
        tbl[2]  = mk(1, 0, 30, 0, 0, 0,  6'd4,  8, 16, 5'b11000); // no match
        tbl[3]  = mk(1, 1, 8,  8, 0, 0,  6'd4,  8, 16, 5'b00111); // branch after load
        tbl[4]  = mk(0, 0, 0,  0, 1, 16, 6'd4,  8, 16, 5'b00111); // load in MEM
        tbl[5]  = mk(0, 1, 0,  16, 0, 0, 6'd4,  8, 16, 5'b00110); // branch after ALU
        tbl[6]  = mk(0, 1, 0,  8, 0, 0,  6'd5,  8, 16, 5'b00110); // bne, rs match
        tbl[7]  = mk(1, 0, 8,  0, 0, 0,  6'd2,  8, 8,  5'b11000); // jump reads nothing
        tbl[8]  = mk(1, 0, 8,  0, 0, 0,  6'd35, 3, 8,  5'b11000); // lw rt not a source
        tbl[9]  = mk(1, 0, 8,  0, 0, 0,  6'd43, 3, 8,  5'b00101); // sw reads rt
        tbl[10] = mk(0, 1, 0,  8, 1, 16, 6'd4,  8, 16, 5'b00111); // tie: 11 beats 10

        for (int k = 0; k < 3; k++) begin m_rem[k] = 0; m_cnt[k] = 0; m_code[k] = 0; end
        quiet();
        rst = 1;
        #1;
        step(1, 5'b00100, "reset_out");
        step(1, 5'b00100, "reset_out2");
        rst = 0;
        step(1, 5'b11000, "release_idle");

        foreach (tbl[i]) begin
            c0 = longint'(sc1);
            set_in(tbl[i]);
            step(1, tbl[i].exp, $sformatf("vec%0d", i));
            quiet();
            repeat (5) step(0, 5'b0, "");
            if (i == 0) chk("lu3_three_bubbles", longint'(sc1) - c0, 3);
        end

        // Hold in the first STALL cycle of a 2-bubble branch-after-load.
        set_in(tbl[3]);
        step(1, 5'b00111, "hold_arm");
        quiet();
        hold = 1;
        c0 = longint'(sc0);
        repeat (3) step(0, 5'b0, "");
        chk("hold_cnt_frozen", longint'(sc0), c0);
        hold = 0;
        step(1, 5'b00111, "hold_resume");
        step(1, 5'b11000, "hold_done");
        repeat (4) step(0, 5'b0, "");

        // Reset pulse while u3 is mid-STALL.
        set_in(tbl[0]);
        step(1, 5'b00101, "rst_arm");
        quiet();
        step(1, 5'b11000, "rst_u3_stalling");
        rst = 1;
        step(1, 5'b00100, "rst_mid");
        chk("rst_u3_cnt", longint'(sc1), 0);
        rst = 0;
        step(1, 5'b11000, "rst_release");

        // Randomised traffic with small register numbers to provoke hazards.
        for (int j = 0; j < 2000; j++) begin
            logic [5:0] ops[8];
            ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd2, 6'd3, 6'd15, 6'd35};
            mr   = ($urandom_range(0, 1) == 1);
            rw   = ($urandom_range(0, 1) == 1);
            emr  = ($urandom_range(0, 3) == 0);
            irt  = 5'($urandom_range(0, 3));
            idst = 5'($urandom_range(0, 3));
            edst = 5'($urandom_range(0, 3));
            ins  = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            hold = ($urandom_range(0, 99) < 10);
            rst  = ($urandom_range(0, 199) == 0);
            step(0, 5'b0, "");
            rst = 0;
        end
        chk("sat_reached", longint'(sc2) <= 15, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdu_seq.md
Name: hdu_seq

Overview:
Parametrised, sequential successor to the pipeline hazard detection unit. It detects load-use hazards and branch-operand hazards (branches resolved in ID) and holds PC/IF-ID for a fixed, parameter-driven number of cycles using a stall counter FSM, so stall length no longer depends on upstream inputs staying stable. It also honours an external front-end hold and exposes a hazard code and a stall performance counter.

Parameters:
REG_W, 5, register address width
OP_W, 6, opcode width; instruction2msb_in is OP_W+2*REG_W bits
LOAD_USE_STALLS, 1, bubbles inserted for a load-use hazard (legal 1..3)
BRANCH_IN_ID, 1, 1 = branch compare happens in ID, so branch-operand hazards are detected; 0 = branch hazards ignored
BEQ_OP, 6'b000100, beq opcode
BNE_OP, 6'b000101, bne opcode
PERF_W, 32, stall counter width

Ports:
clock_in  in  1  clock, rising edge
reset_in  in  1  asynchronous, active-high reset
hold_in  in  1  external front-end freeze (e.g. I-cache miss)
id_ex_memRead  in  1  instruction in EX is a load
id_ex_regWrite  in  1  instruction in EX writes a register
id_ex_rt  in  REG_W  load destination in EX
id_ex_dst  in  REG_W  resolved writeback register in EX
ex_mem_memRead  in  1  instruction in MEM is a load
ex_mem_dst  in  REG_W  load destination in MEM
instruction2msb_in  in  OP_W+2*REG_W  upper IF/ID instruction bits {opcode, rs, rt}
pc_wr_out  out  1  PC write enable
if_id_wr_out  out  1  IF/ID write enable
flush_control_out  out  1  zero ID/EX control (insert bubble)
hazard_out  out  2  00 none, 01 load-use, 10 branch-after-ALU, 11 branch-after-load
stall_count_out  out  PERF_W  total bubbles inserted, saturating

Behaviour:
- Decode: opcode=[top OP_W], rs=[2*REG_W-1:REG_W], rt=[REG_W-1:0]. rt_used when opcode is 0, BEQ_OP, BNE_OP, or 6'b101011 (sw). rs_used unless opcode is 2, 3 or 6'b001111. A match on register 0 is never a hazard.
- Stall demands, computed in IDLE:
  - Load-use: id_ex_memRead and id_ex_rt matches a used rs/rt. Demand LOAD_USE_STALLS, code 01.
  - If BRANCH_IN_ID and opcode is BEQ/BNE:
    - id_ex_memRead and id_ex_rt matches rs or rt. Demand LOAD_USE_STALLS+1, code 11.
    - Otherwise, id_ex_regWrite and id_ex_dst matches. Demand 1, code 10.
    - ex_mem_memRead and ex_mem_dst matches. Demand LOAD_USE_STALLS, code 11.
- Resolution: the largest demand wins. Equal demands prioritise 11 > 01 > 10.
- FSM states IDLE and STALL, with a counter cnt sized for LOAD_USE_STALLS+1.
  - IDLE, no hazard: outputs 1,1,0 and hazard_out=00.
  - IDLE, demand N: outputs 0,0,1 combinationally in the same cycle and hazard_out = code. If N>1, cnt<=N-1 and go to STALL.
  - STALL: outputs 0,0,1 and hazard_out holds the latched code. New detection is ignored. cnt decrements each cycle; when cnt==1, the next state is IDLE.
- hold_in has priority over everything except reset:
  - Outputs are pc_wr=0, if_id_wr=0, flush=0.
  - State, cnt and stall_count_out are frozen.
  - No new stall is started; detection resumes the cycle after hold_in drops.
- stall_count_out: +1 on every cycle with flush_control_out=1 outside reset, saturating at all-ones.
- Reset (asynchronous, any time, including mid-STALL):
  - State IDLE, cnt=0, latched code 00, stall_count_out=0.
  - While reset_in is high, outputs are pc_wr=0, if_id_wr=0, flush=1, hazard_out=00.
  - The first cycle after release follows IDLE rules.

Test Plan:
- Reset: reset_in=1 -> outputs 0,0,1, hazard 00, stall_count 0. Release with quiet inputs -> 1,1,0.
- Load-use: memRead=1, id_ex_rt=8, instr 000000_01000_10000 -> one cycle 0,0,1 with hazard 01. Next cycle (memRead=0) -> 1,1,0, stall_count=1. Repeat with LOAD_USE_STALLS=3 -> exactly 3 bubble cycles.
- Zero register: memRead=1, id_ex_rt=0, instr 000000_00000_00000 -> 1,1,0, no count change. id_ex_rt=30 with instr 000100_01000_10000 -> no stall.
- Branch after load: memRead=1, regWrite=1, rt=dst=8, instr 000100_01000_10000; inputs cleared after one cycle -> 2 bubble cycles with hazard 11, stall_count +2. Load in MEM (ex_mem_dst=16) with same instr -> 1 bubble.
- Branch after ALU: regWrite=1, memRead=0, dst=16, beq rt=16 -> 1 bubble with hazard 10. With BRANCH_IN_ID=0 -> no stall.
- hold_in asserted in the first STALL cycle for 3 cycles -> outputs 0,0,0 and cnt/stall_count frozen; the remaining bubble follows release. reset_in pulsed mid-STALL -> IDLE and counters zeroed.
